// File: rtl/dram_lsu_pkg.sv
// Shared types for the dram load/store unit: access-size encodings, FSM states,
// lane count and the alignment rule used when misalignment checking is enabled.
package dram_lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_e;

    // A request is illegal when its low address bits do not match its natural alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// Core request/response channel plus dram initiator signals of the load/store unit.
interface dram_lsu_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_mw;
    logic [31:0]   mem_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data, mem_mw
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data, mem_mw
    );
endinterface

// File: rtl/dram_lsu_lane.sv
// Combinational byte-lane logic: little-endian load extraction with sign/zero
// extension, and the read-modify-write merge for sub-word stores.
module dram_lsu_lane
    import dram_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = mem_word[{addr_lo, 3'b000} +: 8];
        half_sel  = mem_word[{addr_lo[1], 4'b0000} +: 16];
        load_data = mem_word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: load_data = mem_word;
        endcase
    end

    // Each lane either takes the matching store byte or keeps the word just read.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(gi);
            logic       hit;
            logic [7:0] src;

            always_comb begin
                hit = 1'b1;
                src = wdata[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        hit = (addr_lo == LANE_IDX);
                        src = wdata[7:0];
                    end
                    SZ_HALF: begin
                        hit = (addr_lo[1] == LANE_IDX[1]);
                        src = wdata[8*(gi%2) +: 8];
                    end
                    default: begin
                        hit = 1'b1;
                        src = wdata[8*gi +: 8];
                    end
                endcase
            end

            assign merge_data[8*gi +: 8] = hit ? src : mem_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dram_lsu.sv
// Load/store unit driving a single-port dram; sub-word stores are read-modify-write.
// Build option MISALIGN_CHECK_EN: reject misaligned and reserved-size requests with rsp_err.
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic CLK,
    input  logic RST,
    dram_lsu_if.slave bus
);

    state_e        state_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic [DW-1:0] rsp_rdata_reg;
    logic          rsp_err_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_data_reg;
    logic          mem_mw_reg;

    logic          we_reg;
    logic          unsigned_reg;
    logic [1:0]    alo_reg;
    size_e         size_reg;
    logic [DW-1:0] wdata_reg;

    size_e         size_norm;
    logic          req_err;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merge_data;
    logic          unused_addr_bits;

    // Upper address bits alias onto the dram depth.
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    // Reserved size behaves as a word access whenever it is not rejected.
    assign size_norm = (bus.req_size == SZ_RSVD) ? SZ_WORD : size_e'(bus.req_size);

`ifdef MISALIGN_CHECK_EN
    assign req_err = is_misaligned(bus.req_addr[1:0], bus.req_size);
`else
    assign req_err = 1'b0;
`endif

    dram_lsu_lane u_lane (
        .addr_lo     (alo_reg),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .mem_word    (bus.mem_q),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            mem_mw_reg    <= 1'b0;
            we_reg        <= 1'b0;
            unsigned_reg  <= 1'b0;
            alo_reg       <= 2'b00;
            size_reg      <= SZ_BYTE;
            wdata_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_reg        <= bus.req_we;
                        unsigned_reg  <= bus.req_unsigned;
                        alo_reg       <= bus.req_addr[1:0];
                        size_reg      <= size_norm;
                        wdata_reg     <= bus.req_wdata;
                        mem_addr_reg  <= bus.req_addr[AW+1:2];
                        req_ready_reg <= 1'b0;
                        if (req_err) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                            state_reg     <= ST_RESP;
                        end else if (bus.req_we && size_norm == SZ_WORD) begin
                            mem_data_reg <= bus.req_wdata;
                            mem_mw_reg   <= 1'b1;
                            state_reg    <= ST_WR;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_mw_reg <= 1'b0;
                    state_reg  <= ST_CAP;
                end
                ST_CAP: begin
                    // mem_q is valid here for dram read latency 0 or 1.
                    if (we_reg) begin
                        mem_data_reg <= merge_data;
                        mem_mw_reg   <= 1'b1;
                        state_reg    <= ST_WR;
                    end else begin
                        rsp_rdata_reg <= load_data;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    mem_mw_reg    <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    rsp_rdata_reg <= '0;
                    state_reg     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= '0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    mem_mw_reg    <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_data  = mem_data_reg;
    assign bus.mem_mw    = mem_mw_reg;

endmodule

// File: tb/tb_dram_lsu.sv
// Self-checking bench for dram_lsu: directed plan items then random traffic,
// checked against an arithmetic reference of memory contents and lane rules.
module tb_dram_lsu;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] dram    [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    dram_lsu_if #(.AW(8)) bus ();

    dram_lsu #(.AW(8), .DW(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dram with one cycle of read latency; writes happen on the edge while MW is high
    always @(posedge clk) begin
        if (bus.mem_mw) dram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= dram[bus.mem_addr];
    end

`ifdef MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input bit uns);
        logic [31:0] r;
        r = v;
        if (!uns && v >= (32'd1 << (bits - 1))) r = v - (32'd1 << bits);
        return r;
    endfunction

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata);
        int unsigned idx;
        int unsigned lo;
        int unsigned sh;
        bit          err;
        logic [31:0] old;
        logic [31:0] exp_word;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          lat;
        int          mw_cnt;
        logic [31:0] mw_addr;
        logic [31:0] mw_data;

        idx = (addr >> 2) % 256;
        lo  = addr % 4;
        old = ref_mem[idx];
        err = CHECK_EN && ((size == 2'd1 && lo % 2 != 0) || (size == 2'd2 && lo != 0) || size == 2'd3);

        exp_word  = old;
        exp_rdata = 32'h0;
        if (size == 2'd0) begin
            sh = 8 * lo;
            exp_word = (old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            if (!we) exp_rdata = ext((old >> sh) & 32'hFF, 8, uns);
        end else if (size == 2'd1) begin
            sh = 16 * (lo / 2);
            exp_word = (old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            if (!we) exp_rdata = ext((old >> sh) & 32'hFFFF, 16, uns);
        end else begin
            exp_word = wdata;
            if (!we) exp_rdata = old;
        end
        if (err) exp_rdata = 32'h0;

        if (err) exp_lat = 1;
        else if (!we) exp_lat = 3;
        else if (size[1]) exp_lat = 2;
        else exp_lat = 4;

        chk("ready_idle", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;

        lat = 99;
        mw_cnt = 0;
        mw_addr = 32'h0;
        mw_data = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_mw) begin
                mw_cnt++;
                mw_addr = {24'h0, bus.mem_addr};
                mw_data = bus.mem_data;
            end
            if (c < 10 && !bus.rsp_valid) chk("ready_busy", {31'h0, bus.req_ready}, 32'h0);
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end

        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, err});
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("mw_count", mw_cnt, (we && !err) ? 1 : 0);
        if (we && !err) begin
            chk("mw_addr", mw_addr, idx);
            chk("mw_data", mw_data, exp_word);
            ref_mem[idx] = exp_word;
        end
        $display("txn we=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, addr, size, uns, wdata, bus.rsp_rdata, bus.rsp_err, lat);

        @(negedge clk);
        chk("rsp_pulse", {31'h0, bus.rsp_valid}, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_mem_addr", {24'h0, bus.mem_addr}, 32'h0);
        chk("rst_mem_data", bus.mem_data, 32'h0);
        chk("rst_mw", {31'h0, bus.mem_mw}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // directed items
        do_req(1'b1, 32'h0000_0000, 2'd2, 1'b0, 32'h0000_0001);
        do_req(1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0);
        do_req(1'b1, 32'h0000_03FC, 2'd2, 1'b0, 32'd21);
        do_req(1'b0, 32'h0000_03FC, 2'd2, 1'b0, 32'h0);
        do_req(1'b0, 32'h0000_0400, 2'd2, 1'b0, 32'h0);
        do_req(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hAABB_CC80);
        do_req(1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0);
        do_req(1'b0, 32'h0000_0010, 2'd0, 1'b1, 32'h0);
        do_req(1'b0, 32'h0000_0012, 2'd1, 1'b0, 32'h0);
        do_req(1'b1, 32'h0000_0011, 2'd0, 1'b0, 32'h0000_005A);
        do_req(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        do_req(1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'h0);
        do_req(1'b1, 32'h0000_0013, 2'd1, 1'b0, 32'h0000_BEEF);
        do_req(1'b1, 32'h0000_0020, 2'd3, 1'b0, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0020, 2'd3, 1'b1, 32'h0);

        // reset while the load sits in RD
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0000_0010;
        bus.req_size = 2'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rstmid_mw", {31'h0, bus.mem_mw}, 32'h0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (bus.rsp_valid) seen++;
            end
            chk("rstmid_no_rsp", seen, 0);
        end
        $display("txn reset during RD of load at 00000010");
        do_req(1'b1, 32'h0000_0018, 2'd0, 1'b0, 32'h0000_0077);
        do_req(1'b0, 32'h0000_0018, 2'd2, 1'b0, 32'h0);

        // random traffic over a few words, with aliased upper address bits
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
